// File: rtl/mips_cpu_reg_writeback.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mips_cpu_reg_writeback                                                     |
// | Merges ALU and memory results into the register file's single write port,  |
// | and keeps the per-register pending-write scoreboard.                       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mips_cpu_reg_writeback #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     mem_valid,
  input  logic [4:0]               mem_reg,
  input  logic [31:0]              mem_data,
  output logic                     mem_ready,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_reg,
  input  logic [31:0]              alu_data,
  output logic                     alu_ready,
  input  logic                     issue_valid,
  input  logic [4:0]               issue_reg,
  output logic [31:0]              busy,
  output logic                     write_enable,
  output logic [4:0]               write_reg,
  output logic [31:0]              write_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int c_aw = $clog2(DEPTH);
  localparam logic [c_aw:0] c_full_m1 = (c_aw + 1)'(DEPTH - 1);
  localparam logic [c_aw:0] c_full_m2 = (c_aw + 1)'(DEPTH - 2);

  logic [4:0]      r_buf_reg  [DEPTH];
  logic [31:0]     r_buf_data [DEPTH];
  logic [c_aw-1:0] r_rd_ptr;
  logic [c_aw-1:0] r_wr_ptr;
  logic [c_aw:0]   r_count;
  logic [31:0]     r_busy;

  logic            w_mem_push;
  logic            w_alu_push;
  logic            w_pop;
  logic [c_aw:0]   w_push_n;
  logic [c_aw:0]   w_pop_n;
  logic [c_aw-1:0] w_alu_idx;
  logic [31:0]     w_set;
  logic [31:0]     w_clr;

  // Readiness depends only on occupancy, not on the pop that will happen this edge
  assign mem_ready = (r_count <= c_full_m1);
  assign alu_ready = mem_valid ? (r_count <= c_full_m2) : (r_count <= c_full_m1);

  // Register-0 results complete the handshake but are dropped here
  assign w_mem_push = mem_valid && mem_ready && (mem_reg != 5'd0);
  assign w_alu_push = alu_valid && alu_ready && (alu_reg != 5'd0);
  assign w_pop      = (r_count != '0);

  assign w_push_n  = (c_aw + 1)'(w_mem_push) + (c_aw + 1)'(w_alu_push);
  assign w_pop_n   = (c_aw + 1)'(w_pop);
  assign w_alu_idx = r_wr_ptr + (c_aw)'(w_mem_push);

  assign write_enable = w_pop;
  assign write_reg    = w_pop ? r_buf_reg[r_rd_ptr]  : 5'd0;
  assign write_data   = w_pop ? r_buf_data[r_rd_ptr] : 32'd0;
  assign count        = r_count;
  assign busy         = r_busy;

  assign w_set = (issue_valid && (issue_reg != 5'd0)) ? (32'd1 << issue_reg) : 32'd0;
  assign w_clr = write_enable ? (32'd1 << write_reg) : 32'd0;

  always_ff @(posedge clk) begin
    if (w_mem_push) begin
      r_buf_reg[r_wr_ptr]  <= mem_reg;
      r_buf_data[r_wr_ptr] <= mem_data;
    end
    if (w_alu_push) begin
      r_buf_reg[w_alu_idx]  <= alu_reg;
      r_buf_data[w_alu_idx] <= alu_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_busy   <= 32'd0;
    end else begin
      r_wr_ptr <= r_wr_ptr + (c_aw)'(w_push_n);
      r_rd_ptr <= r_rd_ptr + (c_aw)'(w_pop);
      r_count  <= r_count + w_push_n - w_pop_n;
      // A new issue to r overrides the retirement of the previous write to r
      r_busy   <= ((r_busy & ~w_clr) | w_set) & ~32'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_cpu_reg_writeback.sv
`default_nettype none
// Randomised and directed checks of mips_cpu_reg_writeback against a queue-based model.
module tb_mips_cpu_reg_writeback;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_valid, alu_valid, issue_valid;
  logic [4:0]  mem_reg, alu_reg, issue_reg;
  logic [31:0] mem_data, alu_data;
  logic        mem_ready, alu_ready;
  logic [31:0] busy;
  logic        write_enable;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [2:0]  count;

  mips_cpu_reg_writeback #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
    .issue_valid(issue_valid), .issue_reg(issue_reg), .busy(busy),
    .write_enable(write_enable), .write_reg(write_reg), .write_data(write_data),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] r; logic [31:0] d; } ent_t;
  ent_t        q[$];
  logic [31:0] m_busy;
  bit          mem_acc, alu_acc;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          seq     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare every output against the model shortly after inputs change
  task automatic settle();
    int n;
    #1;
    n = q.size();
    chk("count", 32'(count), 32'(n));
    chk("write_enable", 32'(write_enable), 32'(n != 0));
    chk("write_reg", 32'(write_reg), (n != 0) ? 32'(q[0].r) : 32'd0);
    chk("write_data", write_data, (n != 0) ? q[0].d : 32'd0);
    chk("mem_ready", 32'(mem_ready), 32'(n <= DEPTH - 1));
    chk("alu_ready", 32'(alu_ready), 32'(mem_valid ? (n <= DEPTH - 2) : (n <= DEPTH - 1)));
    chk("busy", busy, m_busy);
  endtask

  task automatic tick();
    int   n;
    bit   ma, aa, popped;
    logic [4:0] preg;
    n  = q.size();
    ma = mem_valid && (n <= DEPTH - 1);
    aa = alu_valid && (mem_valid ? (n <= DEPTH - 2) : (n <= DEPTH - 1));
    @(posedge clk);
    popped = (n != 0);
    preg   = popped ? q[0].r : 5'd0;
    if (popped) void'(q.pop_front());
    if (ma && mem_reg != 0) q.push_back('{mem_reg, mem_data});
    if (aa && alu_reg != 0) q.push_back('{alu_reg, alu_data});
    for (int r = 1; r < 32; r++) begin
      if (issue_valid && issue_reg == 5'(r)) m_busy[r] = 1'b1;
      else if (popped && preg == 5'(r)) m_busy[r] = 1'b0;
    end
    mem_acc = ma;
    alu_acc = aa;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    mem_valid = 0; mem_reg = 0; mem_data = 0;
    alu_valid = 0; alu_reg = 0; alu_data = 0;
    issue_valid = 0; issue_reg = 0;
  endtask

  function automatic logic [4:0] next_reg();
    seq++;
    return 5'((seq % 31) + 1);
  endfunction

  initial begin
    idle_inputs();
    q.delete();
    m_busy  = 32'd0;
    reset_n = 1'b0;
    #2;
    chk("rst_we", 32'(write_enable), 32'd0);
    chk("rst_reg", 32'(write_reg), 32'd0);
    chk("rst_data", write_data, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_mem_ready", 32'(mem_ready), 32'd1);
    chk("rst_alu_ready", 32'(alu_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;

    // Fill three entries with regs 16 and 20 pending, then reset mid-cycle
    issue_valid = 1; issue_reg = 16;
    mem_valid = 1; mem_reg = 1; mem_data = 32'h11;
    alu_valid = 1; alu_reg = 2; alu_data = 32'h22;
    settle(); tick();
    issue_reg = 20;
    mem_reg = 3; mem_data = 32'h33;
    alu_reg = 4; alu_data = 32'h44;
    settle(); tick();
    idle_inputs();
    settle();
    chk("pre_rst_count", 32'(count), 32'd3);
    chk("pre_rst_busy", busy, 32'h0011_0000);
    #1 reset_n = 1'b0;
    #1;
    q.delete();
    m_busy = 32'd0;
    chk("async_we", 32'(write_enable), 32'd0);
    chk("async_busy", busy, 32'd0);
    chk("async_count", 32'(count), 32'd0);
    chk("async_mem_ready", 32'(mem_ready), 32'd1);
    chk("async_alu_ready", 32'(alu_ready), 32'd1);
    #1 reset_n = 1'b1;
    @(negedge clk);

    // Single write
    issue_valid = 1; issue_reg = 16;
    settle(); tick();
    idle_inputs();
    alu_valid = 1; alu_reg = 16; alu_data = 32'd1234567;
    settle();
    chk("single_busy_set", 32'(busy[16]), 32'd1);
    tick();
    idle_inputs();
    settle();
    chk("single_we", 32'(write_enable), 32'd1);
    chk("single_reg", 32'(write_reg), 32'd16);
    chk("single_data", write_data, 32'd1234567);
    tick();
    settle();
    chk("single_busy_clr", 32'(busy[16]), 32'd0);

    // Dual same-edge transfer
    mem_valid = 1; mem_reg = 16; mem_data = 32'd1234567;
    alu_valid = 1; alu_reg = 20; alu_data = 32'd7654321;
    settle(); tick();
    idle_inputs();
    settle();
    chk("dual_count0", 32'(count), 32'd2);
    chk("dual_reg0", 32'(write_reg), 32'd16);
    chk("dual_data0", write_data, 32'd1234567);
    tick(); settle();
    chk("dual_count1", 32'(count), 32'd1);
    chk("dual_reg1", 32'(write_reg), 32'd20);
    chk("dual_data1", write_data, 32'd7654321);
    tick(); settle();
    chk("dual_count2", 32'(count), 32'd0);

    // Saturation: both sources continuously offering
    mem_valid = 1; mem_reg = next_reg(); mem_data = $urandom;
    alu_valid = 1; alu_reg = next_reg(); alu_data = $urandom;
    for (int i = 0; i < 12; i++) begin
      settle();
      if (i == 0) chk("sat_count0", 32'(count), 32'd0);
      if (i == 1) chk("sat_count1", 32'(count), 32'd2);
      if (i >= 2) begin
        chk("sat_count_hold", 32'(count), 32'd3);
        chk("sat_alu_stall", 32'(alu_ready), 32'd0);
      end
      tick();
      if (mem_acc) begin mem_reg = next_reg(); mem_data = $urandom; end
      if (alu_acc) begin alu_reg = next_reg(); alu_data = $urandom; end
    end
    idle_inputs();
    for (int i = 0; i < DEPTH + 2; i++) begin settle(); tick(); end

    // Register 0 filtering
    alu_valid = 1; alu_reg = 0; alu_data = 32'hDEADBEEF;
    issue_valid = 1; issue_reg = 0;
    settle();
    chk("r0_alu_ready", 32'(alu_ready), 32'd1);
    tick();
    idle_inputs();
    settle();
    chk("r0_count", 32'(count), 32'd0);
    chk("r0_we", 32'(write_enable), 32'd0);
    chk("r0_busy", busy, 32'd0);

    // Set wins over clear
    issue_valid = 1; issue_reg = 5;
    settle(); tick();
    idle_inputs();
    alu_valid = 1; alu_reg = 5; alu_data = 32'h5555;
    settle(); tick();
    idle_inputs();
    issue_valid = 1; issue_reg = 5;
    settle();
    chk("sw_port_reg", 32'(write_reg), 32'd5);
    tick();
    idle_inputs();
    settle();
    chk("sw_busy5", 32'(busy[5]), 32'd1);
    tick();

    // Randomised traffic with held offers
    idle_inputs();
    for (int i = 0; i < 2000; i++) begin
      settle();
      tick();
      if (!mem_valid || mem_acc) begin
        mem_valid = ($urandom_range(0, 9) < 6);
        mem_reg   = 5'($urandom_range(0, 31));
        mem_data  = $urandom;
      end
      if (!alu_valid || alu_acc) begin
        alu_valid = ($urandom_range(0, 9) < 6);
        alu_reg   = 5'($urandom_range(0, 31));
        alu_data  = $urandom;
      end
      issue_valid = ($urandom_range(0, 1) == 1);
      issue_reg   = 5'($urandom_range(0, 31));
    end
    idle_inputs();
    for (int i = 0; i < DEPTH + 2; i++) begin settle(); tick(); end
    settle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
